// File: rtl/game_ctrl.sv
// Round sequencer for the catch game: arms/reset the faller, runs the start countdown,
// accumulates the multi-round total and keeps the high score. Control outputs lag state by one cycle.
module game_ctrl #(
  parameter int TICK_W   = 26,
  parameter int ROUNDS   = 5,
  parameter int MAX_MISS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic [20:0] seed_in,
  input  logic        drop_end,
  input  logic [3:0]  drop_score,
  input  logic [3:0]  drop_miss,
  output logic        drop_rst,
  output logic        drop_ena,
  output logic [20:0] drop_seed,
  output logic [2:0]  state,
  output logic [1:0]  countdown,
  output logic [3:0]  round,
  output logic [7:0]  total_score,
  output logic [7:0]  high_score,
  output logic        game_over,
  output logic        win
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    COUNT = 3'd2,
    PLAY  = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [3:0] MISS_LIM   = 4'(MAX_MISS);
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_t cur, nxt;

  logic              prev_start, prev_pause, post_rst;
  logic              start_rise, pause_rise;
  logic              arm_cnt, end_armed;
  logic [TICK_W-1:0] tick;
  logic              tick_wrap;
  logic [8:0]        sum9;
  logic [7:0]        sum_sat;
  logic              clr_game, add_score, inc_round, set_win, clr_win;

  // post_rst masks the first cycle after reset so a button held through reset yields no edge
  assign start_rise = btn_start & ~prev_start & ~post_rst;
  assign pause_rise = btn_pause & ~prev_pause & ~post_rst;
  assign tick_wrap  = &tick;
  assign sum9       = {1'b0, total_score} + {5'b0, drop_score};
  assign sum_sat    = sum9[8] ? 8'hFF : sum9[7:0];
  assign state      = cur;

  always_ff @(posedge clk) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt       = cur;
    clr_game  = 1'b0;
    add_score = 1'b0;
    inc_round = 1'b0;
    set_win   = 1'b0;
    clr_win   = 1'b0;
    case (cur)
      IDLE: begin
        if (start_rise) begin
          nxt      = ARM;
          clr_game = 1'b1;
        end
      end
      ARM: begin
        if (arm_cnt) nxt = COUNT;
      end
      COUNT: begin
        if (tick_wrap && countdown == 2'd1) nxt = PLAY;
      end
      PLAY: begin
        if (drop_miss >= MISS_LIM) begin
          nxt       = OVER;
          add_score = 1'b1;
          clr_win   = 1'b1;
        end else if (end_armed && drop_end) begin
          add_score = 1'b1;
          if (round == LAST_ROUND) begin
            nxt     = OVER;
            set_win = 1'b1;
          end else begin
            nxt       = ARM;
            inc_round = 1'b1;
          end
        end else if (pause_rise) begin
          nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (start_rise)      nxt = IDLE;
        else if (pause_rise) nxt = PLAY;
      end
      OVER: begin
        if (start_rise) begin
          nxt      = ARM;
          clr_game = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_start  <= 1'b0;
      prev_pause  <= 1'b0;
      post_rst    <= 1'b1;
      arm_cnt     <= 1'b0;
      end_armed   <= 1'b0;
      tick        <= '0;
      countdown   <= 2'd0;
      round       <= 4'd0;
      total_score <= 8'd0;
      high_score  <= 8'd0;
      win         <= 1'b0;
      drop_seed   <= 21'd0;
      drop_rst    <= 1'b0;
      drop_ena    <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      prev_start <= btn_start;
      prev_pause <= btn_pause;
      post_rst   <= 1'b0;
      drop_rst   <= (cur == ARM);
      drop_ena   <= (cur == PLAY);
      game_over  <= (cur == OVER);
      arm_cnt    <= (cur == ARM) && !arm_cnt;

      if (cur == ARM && !arm_cnt) drop_seed <= seed_in;

      if (cur == ARM && arm_cnt) begin
        countdown <= 2'd3;
        tick      <= '0;
        end_armed <= 1'b0;
      end

      if (cur == COUNT) begin
        tick <= tick + TICK_W'(1);
        if (tick_wrap) countdown <= countdown - 2'd1;
      end

      if (cur == PLAY && !drop_end) end_armed <= 1'b1;

      if (clr_game) begin
        total_score <= 8'd0;
        round       <= 4'd0;
        win         <= 1'b0;
      end
      if (add_score) total_score <= sum_sat;
      if (inc_round) round <= round + 4'd1;
      if (set_win)   win <= 1'b1;
      if (clr_win)   win <= 1'b0;

      if (cur == OVER && total_score > high_score) high_score <= total_score;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with TICK_W=4, ROUNDS=5, MAX_MISS=3.
module tb_game_ctrl;
  logic        clk = 1'b0;
  logic        rst, btn_start, btn_pause, drop_end;
  logic [20:0] seed_in;
  logic [3:0]  drop_score, drop_miss;
  logic        drop_rst, drop_ena, game_over, win;
  logic [20:0] drop_seed;
  logic [2:0]  state;
  logic [1:0]  countdown;
  logic [3:0]  round;
  logic [7:0]  total_score, high_score;

  int n_cmp = 0;
  int n_err = 0;

  game_ctrl #(.TICK_W(4), .ROUNDS(5), .MAX_MISS(3)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
    .seed_in(seed_in), .drop_end(drop_end), .drop_score(drop_score), .drop_miss(drop_miss),
    .drop_rst(drop_rst), .drop_ena(drop_ena), .drop_seed(drop_seed), .state(state),
    .countdown(countdown), .round(round), .total_score(total_score),
    .high_score(high_score), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic finish_round(input logic [3:0] score);
    drop_end = 1'b0;
    step(1);
    drop_score = score;
    drop_end = 1'b1;
    step(1);
  endtask

  initial begin
    rst = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; drop_end = 1'b1;
    seed_in = 21'd0; drop_score = 4'd0; drop_miss = 4'd0;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_state", state, 0);
    chk("rst_drop_rst", drop_rst, 0);
    chk("rst_drop_ena", drop_ena, 0);
    chk("rst_total", total_score, 0);
    chk("rst_high", high_score, 0);
    chk("rst_countdown", countdown, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_seed", drop_seed, 0);

    // game 1: five full rounds of 4 catches
    seed_in = 21'h1ABCD; btn_start = 1'b1;
    step(1);
    chk("g1_arm", state, 1);
    btn_start = 1'b0;
    step(1);
    chk("g1_arm2", state, 1);
    chk("g1_drop_rst", drop_rst, 1);
    chk("g1_seed", drop_seed, 21'h1ABCD);
    seed_in = 21'h0F0F0;
    step(1);
    chk("g1_count", state, 2);
    chk("g1_cd3", countdown, 3);
    chk("g1_seed_held", drop_seed, 21'h1ABCD);
    step(15);
    chk("g1_cd3_end", countdown, 3);
    step(1);
    chk("g1_cd2", countdown, 2);
    step(16);
    chk("g1_cd1", countdown, 1);
    step(15);
    chk("g1_still_count", state, 2);
    step(1);
    chk("g1_play", state, 3);
    chk("g1_cd0", countdown, 0);
    chk("g1_ena_lag", drop_ena, 0);
    step(1);
    chk("g1_ena", drop_ena, 1);
    step(3);
    chk("g1_end_held_state", state, 3);
    chk("g1_end_held_round", round, 0);
    finish_round(4'd4);
    chk("g1_r0_total", total_score, 4);
    chk("g1_r0_round", round, 1);
    chk("g1_r0_arm", state, 1);
    for (int r = 1; r < 4; r++) begin
      step(50);
      chk("g1_loop_play", state, 3);
      finish_round(4'd4);
      chk("g1_loop_total", total_score, 32'(4 * (r + 1)));
      chk("g1_loop_round", round, 32'(r + 1));
    end
    step(50);
    finish_round(4'd4);
    chk("g1_over", state, 5);
    chk("g1_win", win, 1);
    chk("g1_total", total_score, 20);
    chk("g1_round_last", round, 4);
    step(1);
    chk("g1_game_over", game_over, 1);
    chk("g1_high", high_score, 20);
    chk("g1_ena_off", drop_ena, 0);

    // game 2: miss limit in the second round
    btn_start = 1'b1;
    step(1);
    chk("g2_arm", state, 1);
    chk("g2_clr_total", total_score, 0);
    chk("g2_clr_round", round, 0);
    chk("g2_clr_win", win, 0);
    btn_start = 1'b0;
    step(50);
    finish_round(4'd4);
    chk("g2_r0_total", total_score, 4);
    step(50);
    drop_end = 1'b0;
    step(1);
    drop_miss = 4'd3; drop_score = 4'd2;
    step(1);
    chk("g2_over", state, 5);
    chk("g2_total", total_score, 6);
    chk("g2_win", win, 0);
    step(1);
    chk("g2_high_kept", high_score, 20);
    chk("g2_game_over", game_over, 1);
    drop_miss = 4'd0; drop_end = 1'b1;

    // reset in OVER with start held through it
    btn_start = 1'b1; rst = 1'b1;
    step(1);
    chk("rov_state", state, 0);
    chk("rov_high", high_score, 0);
    chk("rov_total", total_score, 0);
    chk("rov_game_over", game_over, 0);
    chk("rov_seed", drop_seed, 0);
    rst = 1'b0;
    step(3);
    chk("rov_held_idle", state, 0);
    btn_start = 1'b0;
    step(1);

    // game 3: pause, resume with end_armed kept, then abort from pause
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    step(50);
    chk("g3_play", state, 3);
    drop_end = 1'b0;
    step(1);
    btn_pause = 1'b1;
    step(1);
    chk("g3_pause", state, 4);
    btn_pause = 1'b0; drop_end = 1'b1; drop_score = 4'd3;
    step(1);
    chk("g3_pause_ena", drop_ena, 0);
    step(3);
    chk("g3_pause_hold", state, 4);
    chk("g3_pause_round", round, 0);
    btn_pause = 1'b1;
    step(1);
    chk("g3_resume", state, 3);
    btn_pause = 1'b0;
    step(1);
    chk("g3_armed_end", state, 1);
    chk("g3_total", total_score, 3);
    chk("g3_round", round, 1);
    step(50);
    btn_pause = 1'b1;
    step(1);
    chk("g3_pause2", state, 4);
    btn_pause = 1'b0;
    step(1);
    btn_start = 1'b1; btn_pause = 1'b1;
    step(1);
    chk("g3_abort", state, 0);
    btn_start = 1'b0; btn_pause = 1'b0;
    step(3);
    chk("g3_no_merge", high_score, 0);

    // reset in COUNT
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    step(12);
    chk("rc_count", state, 2);
    rst = 1'b1;
    step(1);
    chk("rc_state", state, 0);
    chk("rc_countdown", countdown, 0);
    chk("rc_drop_rst", drop_rst, 0);
    chk("rc_total", total_score, 0);
    rst = 1'b0;
    step(2);
    chk("rc_idle", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
